// File: rtl/crypt_sequencer.sv
// LFSR encryption pass controller: fetches config from dat_mem, seeds lfsr6, writes preamble and message.
// Optional CRYPT_CHECKSUM_EN appends a running-XOR checksum byte after the message.
module crypt_sequencer #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int MSG_LEN = 50,
  parameter int SRC_BASE = 0,
  parameter int CFG_BASE = 61,
  parameter int DST_BASE = 64,
  parameter logic [DW-1:0] PAD_CHAR = DW'(8'h5f)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          write_en,
  output logic [AW-1:0] raddr,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] data_in,
  input  logic [DW-1:0] data_out,
  output logic          lfsr_en,
  output logic          lfsr_load,
  output logic [5:0]    taps,
  output logic [5:0]    seed,
  input  logic [5:0]    lfsr_state
);

  // state     | meaning
  // S_IDLE    | waiting for start
  // S_LD_PRE  | latch clamped pre_len
  // S_LD_TAPS | latch taps
  // S_LD_SEED | latch seed, reject zero taps/seed
  // S_SEED    | load LFSR, clear index
  // S_PRE     | write scrambled preamble
  // S_MSG     | write scrambled message
  // S_CSUM    | write checksum (CRYPT_CHECKSUM_EN only)
  // S_DONE    | pass finished, done/err held
  typedef enum logic [3:0] {
    S_IDLE, S_LD_PRE, S_LD_TAPS, S_LD_SEED, S_SEED, S_PRE, S_MSG, S_CSUM, S_DONE
  } state_t;

`ifdef CRYPT_CHECKSUM_EN
  localparam int unsigned PRE_MAX = (1 << AW) - DST_BASE - MSG_LEN - 1;
`else
  localparam int unsigned PRE_MAX = (1 << AW) - DST_BASE - MSG_LEN;
`endif
  localparam logic [AW-1:0] L_CFG = AW'(CFG_BASE);
  localparam logic [AW-1:0] L_SRC = AW'(SRC_BASE);
  localparam logic [AW-1:0] L_DST = AW'(DST_BASE);
  localparam logic [AW-1:0] L_MSG_LAST = AW'(MSG_LEN - 1);

  state_t        r_state;
  logic          r_busy, r_done, r_err;
  logic [5:0]    r_taps, r_seed;
  logic [AW-1:0] r_pre_len, r_k;
  logic [AW-1:0] w_pre_clamp;
  logic [DW-1:0] w_ks;
`ifdef CRYPT_CHECKSUM_EN
  logic [DW-1:0] r_csum;
`endif

  assign busy  = r_busy;
  assign done  = r_done;
  assign err   = r_err;
  assign taps  = r_taps;
  assign seed  = r_seed;
  assign w_ks  = {{(DW-6){1'b0}}, lfsr_state};

  // Saturate so the last write address never wraps past 2**AW-1.
  always_comb begin
    w_pre_clamp = AW'(data_out);
    if (32'(data_out) > PRE_MAX) w_pre_clamp = AW'(PRE_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_taps    <= '0;
      r_seed    <= '0;
      r_pre_len <= '0;
      r_k       <= '0;
`ifdef CRYPT_CHECKSUM_EN
      r_csum    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LD_PRE;
            r_busy  <= 1'b1;
          end
        end
        S_LD_PRE: begin
          r_pre_len <= w_pre_clamp;
          r_state   <= S_LD_TAPS;
        end
        S_LD_TAPS: begin
          r_taps  <= data_out[5:0];
          r_state <= S_LD_SEED;
        end
        S_LD_SEED: begin
          r_seed <= data_out[5:0];
          if (r_taps == 6'd0 || data_out[5:0] == 6'd0) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_state <= S_SEED;
          end
        end
        S_SEED: begin
          r_k     <= '0;
          r_state <= (r_pre_len != '0) ? S_PRE : S_MSG;
`ifdef CRYPT_CHECKSUM_EN
          r_csum  <= '0;
`endif
        end
        S_PRE: begin
`ifdef CRYPT_CHECKSUM_EN
          r_csum <= r_csum ^ data_in;
`endif
          if (r_k == r_pre_len - 1'b1) begin
            r_k     <= '0;
            r_state <= S_MSG;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_MSG: begin
`ifdef CRYPT_CHECKSUM_EN
          r_csum <= r_csum ^ data_in;
`endif
          if (r_k == L_MSG_LAST) begin
`ifdef CRYPT_CHECKSUM_EN
            r_state <= S_CSUM;
`else
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
`endif
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_CSUM: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end
        S_DONE: begin
          if (start) begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_LD_PRE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    write_en  = 1'b0;
    lfsr_en   = 1'b0;
    lfsr_load = 1'b0;
    raddr     = '0;
    waddr     = '0;
    data_in   = '0;
    case (r_state)
      S_LD_PRE:  raddr = L_CFG;
      S_LD_TAPS: raddr = L_CFG + AW'(1);
      S_LD_SEED: raddr = L_CFG + AW'(2);
      S_SEED:    lfsr_load = 1'b1;
      S_PRE: begin
        write_en = 1'b1;
        lfsr_en  = 1'b1;
        waddr    = L_DST + r_k;
        data_in  = PAD_CHAR ^ w_ks;
      end
      S_MSG: begin
        write_en = 1'b1;
        lfsr_en  = 1'b1;
        raddr    = L_SRC + r_k;
        waddr    = L_DST + r_pre_len + r_k;
        data_in  = data_out ^ w_ks;
      end
`ifdef CRYPT_CHECKSUM_EN
      S_CSUM: begin
        write_en = 1'b1;
        waddr    = L_DST + r_pre_len + L_MSG_LAST + AW'(1);
        data_in  = r_csum;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_crypt_sequencer.sv
// Directed bench for crypt_sequencer with a behavioural dat_mem and lfsr6 model.
module tb_crypt_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, err, write_en, lfsr_en, lfsr_load;
  logic [7:0] raddr, waddr, data_in, data_out;
  logic [5:0] taps, seed, lfsr_state;

  crypt_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .write_en(write_en), .raddr(raddr), .waddr(waddr), .data_in(data_in),
    .data_out(data_out), .lfsr_en(lfsr_en), .lfsr_load(lfsr_load),
    .taps(taps), .seed(seed), .lfsr_state(lfsr_state)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic [7:0] exp_mem [256];
  logic [5:0] m_state, m_taps;
  int tests = 0, fails = 0;
  int wcnt = 0, ecnt = 0, both_cnt = 0;
  logic [7:0] first_wa, first_wd, last_wa;

  assign data_out   = mem[raddr];
  assign lfsr_state = m_state;

  function automatic logic [5:0] step(input logic [5:0] s, input logic [5:0] t);
    return {s[4:0], ^(s & t)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= '0;
      m_taps  <= '0;
    end else if (lfsr_load) begin
      m_state <= seed;
      m_taps  <= taps;
    end else if (lfsr_en) begin
      m_state <= step(m_state, m_taps);
    end
  end

  always @(posedge clk) begin
    if (write_en) begin
      if (wcnt == 0) begin
        first_wa = waddr;
        first_wd = data_in;
      end
      mem[waddr] <= data_in;
      last_wa = waddr;
      wcnt++;
    end
    if (lfsr_en) ecnt++;
    if (lfsr_en && lfsr_load) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_dst();
    for (int i = 64; i < 256; i++) mem[i] = 8'h00;
    wcnt = 0;
    ecnt = 0;
    first_wa = 8'h00;
    first_wd = 8'h00;
    last_wa = 8'h00;
  endtask

  task automatic load_cfg(input logic [7:0] p, input logic [7:0] t, input logic [7:0] s);
    for (int i = 0; i < 64; i++) mem[i] = 8'(i * 37 + 11);
    mem[61] = p;
    mem[62] = t;
    mem[63] = s;
    clear_dst();
  endtask

  task automatic build_exp(input int p, input logic [5:0] t, input logic [5:0] s);
    int pc;
    logic [5:0] st;
    pc = (p > 142) ? 142 : p;
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
    st = s;
    for (int k = 0; k < pc; k++) begin
      exp_mem[64 + k] = 8'h5f ^ {2'b00, st};
      st = step(st, t);
    end
    for (int j = 0; j < 50; j++) begin
      exp_mem[64 + pc + j] = mem[j] ^ {2'b00, st};
      st = step(st, t);
    end
  endtask

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 64; i < 256; i++) if (mem[i] !== exp_mem[i]) n++;
    return n;
  endfunction

  // Called #1 after the edge that accepted start; counts edges until done.
  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (!done && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  int lat, saved;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_taps_seed", {taps, seed}, 0);
    check("rst_we", write_en, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal pass
    load_cfg(8'd7, 8'h21, 8'h01);
    build_exp(7, 6'h21, 6'h01);
    pulse_start();
    check("busy_after_start", busy, 1);
    wait_done(0, lat);
    check("t1_latency", lat, 61);
    check("t1_wcnt", wcnt, 57);
    check("t1_ecnt", ecnt, 57);
    check("t1_first_waddr", first_wa, 8'd64);
    check("t1_first_data", first_wd, 8'h5e);
    check("t1_last_waddr", last_wa, 8'd120);
    check("t1_mem", mem_diffs(), 0);
    check("t1_busy", busy, 0);
    check("t1_err", err, 0);
    check("t1_taps", taps, 6'h21);
    check("t1_seed", seed, 6'h01);

    // Empty preamble
    load_cfg(8'd0, 8'h21, 8'h01);
    build_exp(0, 6'h21, 6'h01);
    pulse_start();
    wait_done(0, lat);
    check("t2_latency", lat, 54);
    check("t2_first_waddr", first_wa, 8'd64);
    check("t2_first_data", first_wd, 8'h0a);
    check("t2_wcnt", wcnt, 50);
    check("t2_mem", mem_diffs(), 0);

    // Zero taps abort
    load_cfg(8'd7, 8'h00, 8'h01);
    pulse_start();
    repeat (5) @(posedge clk);
    #1;
    check("t3_done", done, 1);
    check("t3_err", err, 1);
    check("t3_busy", busy, 0);
    check("t3_wcnt", wcnt, 0);
    check("t3_ecnt", ecnt, 0);

    // Saturated preamble
    load_cfg(8'hff, 8'h21, 8'h01);
    build_exp(255, 6'h21, 6'h01);
    pulse_start();
    check("t4_err_cleared", err, 0);
    wait_done(0, lat);
    check("t4_latency", lat, 196);
    check("t4_last_waddr", last_wa, 8'd255);
    check("t4_wcnt", wcnt, 192);
    check("t4_mem", mem_diffs(), 0);

    // Reset in the middle of the message
    load_cfg(8'd7, 8'h21, 8'h01);
    build_exp(7, 6'h21, 6'h01);
    pulse_start();
    repeat (31) @(posedge clk);
    #1;
    check("t5_msg_j20_waddr", waddr, 8'd91);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_ctl", {write_en, lfsr_en, lfsr_load, busy, done, err}, 0);
    check("t5_rst_addr", {raddr, waddr, data_in}, 0);
    check("t5_rst_cfg", {taps, seed}, 0);
    saved = wcnt;
    repeat (4) @(posedge clk);
    #1;
    check("t5_no_writes", wcnt, saved);
    @(negedge clk);
    rst_n = 1'b1;
    clear_dst();
    pulse_start();
    wait_done(0, lat);
    check("t5_rerun_latency", lat, 61);
    check("t5_rerun_mem", mem_diffs(), 0);

    // start pulsed during PRE is ignored
    clear_dst();
    pulse_start();
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(6, lat);
    check("t6_latency", lat, 61);
    check("t6_wcnt", wcnt, 57);
    check("t6_mem", mem_diffs(), 0);

    // start held across a pass and into DONE re-arms once done is reached
    clear_dst();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    check("t7_done_cleared", done, 0);
    check("t7_busy", busy, 1);
    wait_done(0, lat);
    check("t7_held_latency", lat, 61);
    clear_dst();
    @(posedge clk);
    #1;
    start = 1'b0;
    check("t7_rearm_done", done, 0);
    check("t7_rearm_busy", busy, 1);
    wait_done(0, lat);
    check("t7_second_latency", lat, 61);
    check("t7_second_wcnt", wcnt, 57);
    check("t7_second_mem", mem_diffs(), 0);
    check("load_en_overlap", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/crypt_sequencer.md
Name: crypt_sequencer

Overview:
- FSM controller that runs one LFSR encryption pass over dat_mem and drives an external lfsr6 core.
- Replaces the hand-decoded program-counter control in the Lab 4 top level.
- On a start pulse it does the following, then signals done:
  - fetches pre_len, taps and seed from the config words;
  - seeds the LFSR;
  - writes the scrambled preamble;
  - writes the scrambled message.
- Sits between dat_mem and lfsr6 inside top_level.

Parameters:
- AW, 8: dat_mem address width.
- DW, 8: dat_mem data width.
- MSG_LEN, 50: message bytes per pass.
- SRC_BASE, 0: first plaintext address.
- CFG_BASE, 61: pre_len at CFG_BASE, taps at +1, seed at +2.
- DST_BASE, 64: first ciphertext address.
- PAD_CHAR, 8'h5f: preamble character.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- start, in, 1: begin a pass; sampled only in IDLE or DONE.
- busy, out, 1: high while a pass is in progress.
- done, out, 1: pass complete; sticky.
- err, out, 1: pass aborted on an illegal configuration; sticky with done.
- write_en, out, 1: dat_mem write enable.
- raddr, out, AW: dat_mem read address.
- waddr, out, AW: dat_mem write address.
- data_in, out, DW: dat_mem write data.
- data_out, in, DW: dat_mem read data; combinational, valid in the same cycle as raddr.
- lfsr_en, out, 1: advance LFSR.
- lfsr_load, out, 1: copy taps/seed into LFSR.
- taps, out, 6: registered feedback pattern.
- seed, out, 6: registered start state.
- lfsr_state, in, 6: current LFSR value.

Behaviour:
- Reset, asynchronous when rst_n=0:
  - state goes to IDLE.
  - busy, done, err, taps, seed and the internal pre_len and index counter are cleared.
  - Reset mid-pass abandons the pass immediately; no further writes occur.
- Outputs are combinational from the state. Defaults are write_en=0, lfsr_en=0, lfsr_load=0, raddr=0, waddr=0, data_in=0.
- States (one cycle each unless noted):
  - IDLE: start=1 moves to LD_PRE and sets busy=1.
  - LD_PRE: raddr=CFG_BASE; pre_len <= data_out.
  - LD_TAPS: raddr=CFG_BASE+1; taps <= data_out[5:0].
  - LD_SEED: raddr=CFG_BASE+2; seed <= data_out[5:0].
    - If taps==0 or data_out[5:0]==0, set err=1 and go to DONE with no writes.
  - SEED: lfsr_load=1.
    - Go to PRE if pre_len!=0, else to MSG.
    - Clear the index counter k.
  - PRE, pre_len cycles, k=0..pre_len-1:
    - write_en=1, lfsr_en=1, waddr=DST_BASE+k.
    - data_in = PAD_CHAR ^ {2'b00, lfsr_state}.
  - MSG, MSG_LEN cycles, j=0..MSG_LEN-1:
    - write_en=1, lfsr_en=1.
    - raddr=SRC_BASE+j, waddr=DST_BASE+pre_len+j.
    - data_in = data_out ^ {2'b00, lfsr_state}.
  - DONE: busy=0, done=1. start=1 clears done and err and goes to LD_PRE.
- Latency: with a start accepted at edge E, done rises at edge E+4+pre_len+MSG_LEN.
- pre_len clamp:
  - The value is saturated to 2**AW - DST_BASE - MSG_LEN (default 142), so waddr never wraps.
  - The clamp is applied when pre_len is latched in LD_PRE.
- start while busy is ignored. A start held high in DONE re-arms on the first sampling edge.
- All address arithmetic is AW bits wide. data_in MSBs [7:6] pass through from PAD_CHAR or data_out.
- lfsr_en is never asserted together with lfsr_load.

Optional Feature:
- Macro: CRYPT_CHECKSUM_EN.
- Defined:
  - An extra state CSUM follows MSG.
  - It writes the running XOR of every data_in written this pass to DST_BASE+pre_len+MSG_LEN, with write_en=1 and lfsr_en=0.
  - The pre_len clamp drops by 1.
  - done is delayed by one cycle.
- Undefined: CSUM and the accumulator are absent, and MSG goes directly to DONE.

Test Plan:
- Config pre_len=7, taps=6'h21, seed=6'h01; pulse start.
  - First write is waddr=64, data=8'h5e.
  - There are 7 preamble writes, then 50 message writes at 71..120.
  - All data matches the software LFSR model.
  - done rises 61 edges after start.
- Same config with pre_len=0: the first write is waddr=64 = mem[0]^8'h01, and done rises at start+54.
- taps=0: err=1 and done=1 five edges after start, with no write_en pulses and no lfsr_en.
- pre_len=8'hff: clamped to 142; the last write is at waddr=255 with no wrap, and done rises at start+196.
- rst_n low during MSG at j=20:
  - All outputs go to 0 asynchronously.
  - No writes follow.
  - A new start after release reruns the pass with output identical to the first test.
- start pulsed in PRE is ignored. start held high through DONE launches a second pass whose output is identical to the first.
